controle_rodadas: RTL and testbench
===================================

# controle_rodadas

Round and error tracker feeding the scoring stage. Sequences a game through its 8 or 16 rounds and counts the player's errors within the current round. It drives the round index, the per-round error count, the score-register clear strobe and the score-register load strobe. The scoring stage turns these into accumulated points.

## Interface
Parameters:
- `MAX_ERROS`, 4'd15: per-round error count at which the round is force-closed. Range 1..15.

Ports:
- `clock`  in  1  sole clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `iniciar`  in  1  start-game request. Honoured only in IDLE or FIM.
- `nivel`  in  1  0 = 8 rounds, 1 = 16 rounds. Sampled only in IDLE/FIM, on the cycle `iniciar` is accepted.
- `jogada`  in  1  one-cycle pulse: the player made a move.
- `acertou`  in  1  qualifies `jogada`: 1 = correct, 0 = error.
- `fim_rodada`  in  1  one-cycle pulse: the player completed the round's sequence.
- `limite`  out  4  0-based index of the current round.
- `erros`  out  4  errors in the current round, saturating.
- `zera_pontos`  out  1  one-cycle strobe that clears the score register.
- `reg_pontos`  out  1  one-cycle strobe that loads the score register.
- `ultima_rodada`  out  1  high while `limite` is the last round of the latched level.
- `fim_jogo`  out  1  high in FIM.
- `estado`  out  3  current state, for debug.

## Operation
States and transitions:
- IDLE → INIT when `iniciar`=1. `nivel` is latched internally on this cycle.
- INIT → JOGANDO unconditionally. In INIT, `zera_pontos`=1, `limite`←0 and `erros`←0.
- JOGANDO → REGISTRA when either of these holds:
  - `fim_rodada`=1;
  - an error is counted such that `erros` reaches `MAX_ERROS`.
- In JOGANDO, each cycle with `jogada`=1 and `acertou`=0 increments `erros`. The count saturates at 15 and never wraps.
- In JOGANDO, `jogada`=1 with `acertou`=1 has no effect.
- REGISTRA → JOGANDO when the round is not the last. On that edge `limite`←`limite`+1 and `erros`←0.
- REGISTRA → FIM when the round is the last. `limite` and `erros` hold.
- In REGISTRA, `reg_pontos`=1. `limite` and `erros` are stable for the whole cycle.
- FIM → INIT when `iniciar`=1. `nivel` is re-latched on this cycle.

Last-round rule:
- `ultima_rodada` = (`limite` == 7) when the latched level is 0.
- `ultima_rodada` = (`limite` == 15) when the latched level is 1.

Boundary conditions:
- `jogada`&!`acertou` and `fim_rodada` in the same JOGANDO cycle: the error is counted first, so the registered `erros` includes it.
- All inputs are ignored in INIT and REGISTRA. A move arriving in either state is dropped.
- `iniciar` is ignored in JOGANDO and REGISTRA.
- `fim_rodada` is ignored outside JOGANDO.
- `nivel` changes outside IDLE/FIM have no effect.
- `reset` at any point returns the block to IDLE next edge, including mid-round.

Reset values:
- State IDLE, `estado`=0.
- `limite`=0, `erros`=0.
- `zera_pontos`=0, `reg_pontos`=0.
- `fim_jogo`=0, `ultima_rodada`=0.
- Latched level = 0.

## Timing
- All outputs are registered or decoded from registered state only. There is no input-to-output combinational path.
- `iniciar` accepted at edge t:
  - INIT, with `zera_pontos`=1, during cycle t+1;
  - JOGANDO from t+2.
- `fim_rodada` high in cycle t, sampled at edge t:
  - REGISTRA, with `reg_pontos`=1, during cycle t+1;
  - from t+2, either the next round (`limite`+1, `erros`=0) or FIM.
- Error-triggered close follows the same timing as `fim_rodada`.
- Minimum spacing between round closes: 2 cycles.
- Strobes are exactly one cycle wide and are never asserted together.

## Structure
- Package `sinfonia_pkg` holds:
  - the state enum: IDLE=0, INIT=1, JOGANDO=2, REGISTRA=3, FIM=4;
  - `RODADAS_NIVEL0`=8 and `RODADAS_NIVEL1`=16;
  - widths `W_LIMITE`=4 and `W_ERROS`=4.
- One sub-module, `contador_sat`: 4-bit counter with synchronous clear, increment enable and a saturating ceiling input. It is instantiated for `erros`.
- `limite` is a plain counter in the top module.

## Test plan
- Reset, then `iniciar` with `nivel`=0 → `zera_pontos` for exactly 1 cycle; `limite`=0 and `erros`=0 in JOGANDO two cycles after the start pulse.
- 3 error pulses, then `fim_rodada` → `reg_pontos` one cycle with `erros`=3 and `limite`=0; next cycle `limite`=1 and `erros`=0.
- Level 0, 8 clean rounds → 8 `reg_pontos` strobes; `ultima_rodada`=1 at `limite`=7; `fim_jogo`=1 after the 8th strobe. Repeat with level 1 → 16 strobes, ending at `limite`=15.
- Error and `fim_rodada` in the same cycle with `erros`=2 → registered `erros`=3.
- `MAX_ERROS`=4, 4 error pulses and no `fim_rodada` → REGISTRA forced with `erros`=4.
- Assert `reset` mid-round at `limite`=5, `erros`=2 → next cycle IDLE, all outputs 0; `iniciar` restarts at `limite`=0.

Source files
------------

// File: rtl/controle_rodadas_pkg.sv
// sinfonia_pkg
// Shared definitions for the round/error tracker:
//   - estado_t : controller states (IDLE, INIT, JOGANDO, REGISTRA, FIM)
//   - RODADAS_NIVEL0 / RODADAS_NIVEL1 : rounds per game for each level
//   - W_LIMITE / W_ERROS : widths of the round index and error count
//   - ultimo_indice() : 0-based index of the last round for a level
package sinfonia_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        INIT     = 3'd1,
        JOGANDO  = 3'd2,
        REGISTRA = 3'd3,
        FIM      = 3'd4
    } estado_t;

    localparam int RODADAS_NIVEL0 = 8;
    localparam int RODADAS_NIVEL1 = 16;
    localparam int W_LIMITE       = 4;
    localparam int W_ERROS        = 4;

    function automatic logic [W_LIMITE-1:0] ultimo_indice(input logic nivel);
        return nivel ? W_LIMITE'(RODADAS_NIVEL1 - 1) : W_LIMITE'(RODADAS_NIVEL0 - 1);
    endfunction

endpackage

// File: rtl/controle_rodadas_contador_sat.sv
// contador_sat
// Small up-counter that stops at a ceiling instead of wrapping.
// Ports:
//   clock  - rising-edge clock
//   reset  - synchronous active-high reset (count -> 0)
//   clear  - synchronous clear (count -> 0), wins over inc
//   inc    - increment by one when below the ceiling
//   teto   - saturation ceiling
//   valor  - current count (registered)
module contador_sat
    import sinfonia_pkg::*;
#(
    parameter int W = W_ERROS
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clear,
    input  logic         inc,
    input  logic [W-1:0] teto,
    output logic [W-1:0] valor
);

    logic [W-1:0] valor_q;
    logic [W-1:0] valor_d;

    always_comb begin
        valor_d = valor_q;
        if (clear) begin
            valor_d = '0;
        end else if (inc && (valor_q < teto)) begin
            valor_d = valor_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valor_q <= '0;
        end else begin
            valor_q <= valor_d;
        end
    end

    assign valor = valor_q;

endmodule

// File: rtl/controle_rodadas.sv
// controle_rodadas
// Sequences a game through 8 or 16 rounds and counts the player's errors
// in the current round, producing strobes for the scoring stage.
// Ports:
//   clock, reset    - clock and synchronous active-high reset
//   iniciar, nivel  - start request and level (0 = 8 rounds, 1 = 16 rounds)
//   jogada, acertou - move pulse and its correctness qualifier
//   fim_rodada      - player finished the round's sequence
//   limite          - 0-based round index
//   erros           - saturating error count for the current round
//   zera_pontos     - one-cycle score clear strobe (INIT)
//   reg_pontos      - one-cycle score load strobe (REGISTRA)
//   ultima_rodada   - current round is the last one of the latched level
//   fim_jogo        - game over (FIM)
//   estado          - current state, for debug
// Every output comes straight from a flop; flags are precomputed from the
// next-state values so they line up with the state they describe.
module controle_rodadas
    import sinfonia_pkg::*;
#(
    parameter logic [W_ERROS-1:0] MAX_ERROS = 4'd15
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                iniciar,
    input  logic                nivel,
    input  logic                jogada,
    input  logic                acertou,
    input  logic                fim_rodada,
    output logic [W_LIMITE-1:0] limite,
    output logic [W_ERROS-1:0]  erros,
    output logic                zera_pontos,
    output logic                reg_pontos,
    output logic                ultima_rodada,
    output logic                fim_jogo,
    output logic [2:0]          estado
);

    estado_t               estado_q, estado_d;
    logic [W_LIMITE-1:0]   limite_q, limite_d;
    logic                  nivel_q, nivel_d;
    logic                  zera_pontos_q, zera_pontos_d;
    logic                  reg_pontos_q, reg_pontos_d;
    logic                  ultima_rodada_q, ultima_rodada_d;
    logic                  fim_jogo_q, fim_jogo_d;

    logic                  erro_inc;
    logic                  erro_clr;
    logic                  conta_erro;
    logic [W_ERROS-1:0]    erros_q;

    assign conta_erro = jogada && !acertou;

    contador_sat #(
        .W (W_ERROS)
    ) u_erros (
        .clock (clock),
        .reset (reset),
        .clear (erro_clr),
        .inc   (erro_inc),
        .teto  (4'd15),
        .valor (erros_q)
    );

    always_comb begin
        estado_d = estado_q;
        limite_d = limite_q;
        nivel_d  = nivel_q;
        erro_inc = 1'b0;
        erro_clr = 1'b0;

        case (estado_q)
            IDLE, FIM: begin
                if (iniciar) begin
                    estado_d = INIT;
                    nivel_d  = nivel;
                end
            end
            INIT: begin
                estado_d = JOGANDO;
                limite_d = '0;
                erro_clr = 1'b1;
            end
            JOGANDO: begin
                erro_inc = conta_erro;
                // The error in this cycle is counted before deciding the
                // forced close, so reaching the limit closes the round.
                if (fim_rodada ||
                    (conta_erro && (({1'b0, erros_q} + 5'd1) >= {1'b0, MAX_ERROS}))) begin
                    estado_d = REGISTRA;
                end
            end
            REGISTRA: begin
                if (ultima_rodada_q) begin
                    estado_d = FIM;
                end else begin
                    estado_d = JOGANDO;
                    limite_d = limite_q + 1'b1;
                    erro_clr = 1'b1;
                end
            end
            default: begin
                estado_d = IDLE;
            end
        endcase

        zera_pontos_d   = (estado_d == INIT);
        reg_pontos_d    = (estado_d == REGISTRA);
        fim_jogo_d      = (estado_d == FIM);
        ultima_rodada_d = (limite_d == ultimo_indice(nivel_d));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q        <= IDLE;
            limite_q        <= '0;
            nivel_q         <= 1'b0;
            zera_pontos_q   <= 1'b0;
            reg_pontos_q    <= 1'b0;
            ultima_rodada_q <= 1'b0;
            fim_jogo_q      <= 1'b0;
        end else begin
            estado_q        <= estado_d;
            limite_q        <= limite_d;
            nivel_q         <= nivel_d;
            zera_pontos_q   <= zera_pontos_d;
            reg_pontos_q    <= reg_pontos_d;
            ultima_rodada_q <= ultima_rodada_d;
            fim_jogo_q      <= fim_jogo_d;
        end
    end

    assign limite        = limite_q;
    assign erros         = erros_q;
    assign zera_pontos   = zera_pontos_q;
    assign reg_pontos    = reg_pontos_q;
    assign ultima_rodada = ultima_rodada_q;
    assign fim_jogo      = fim_jogo_q;
    assign estado        = estado_q;

endmodule

// File: tb/tb_controle_rodadas.sv
// tb_controle_rodadas
// Directed bench for controle_rodadas. Two instances share the inputs:
// one with the default error limit (15) and one with the limit set to 4.
// Inputs change 1 time unit after a rising edge, outputs are sampled at
// the same point, so each sample reflects the state after that edge.
module tb_controle_rodadas;

    logic       clock;
    logic       reset;
    logic       iniciar;
    logic       nivel;
    logic       jogada;
    logic       acertou;
    logic       fim_rodada;

    logic [3:0] limite, erros;
    logic       zera_pontos, reg_pontos, ultima_rodada, fim_jogo;
    logic [2:0] estado;

    logic [3:0] limite_4, erros_4;
    logic       zera_pontos_4, reg_pontos_4, ultima_rodada_4, fim_jogo_4;
    logic [2:0] estado_4;

    int vectors;
    int miscompares;

    controle_rodadas dut (
        .clock         (clock),
        .reset         (reset),
        .iniciar       (iniciar),
        .nivel         (nivel),
        .jogada        (jogada),
        .acertou       (acertou),
        .fim_rodada    (fim_rodada),
        .limite        (limite),
        .erros         (erros),
        .zera_pontos   (zera_pontos),
        .reg_pontos    (reg_pontos),
        .ultima_rodada (ultima_rodada),
        .fim_jogo      (fim_jogo),
        .estado        (estado)
    );

    controle_rodadas #(
        .MAX_ERROS (4'd4)
    ) dut4 (
        .clock         (clock),
        .reset         (reset),
        .iniciar       (iniciar),
        .nivel         (nivel),
        .jogada        (jogada),
        .acertou       (acertou),
        .fim_rodada    (fim_rodada),
        .limite        (limite_4),
        .erros         (erros_4),
        .zera_pontos   (zera_pontos_4),
        .reg_pontos    (reg_pontos_4),
        .ultima_rodada (ultima_rodada_4),
        .fim_jogo      (fim_jogo_4),
        .estado        (estado_4)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Packed snapshot: {estado, limite, erros, zera, reg, ultima, fim}
    function automatic logic [14:0] obs();
        return {estado, limite, erros, zera_pontos, reg_pontos, ultima_rodada, fim_jogo};
    endfunction

    function automatic logic [14:0] obs4();
        return {estado_4, limite_4, erros_4, zera_pontos_4, reg_pontos_4, ultima_rodada_4, fim_jogo_4};
    endfunction

    function automatic logic [14:0] expv(input logic [2:0] st, input logic [3:0] lim,
                                         input logic [3:0] err, input logic z, input logic r,
                                         input logic u, input logic f);
        return {st, lim, err, z, r, u, f};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        iniciar    = 1'b0;
        jogada     = 1'b0;
        acertou    = 1'b0;
        fim_rodada = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic error_pulse();
        jogada  = 1'b1;
        acertou = 1'b0;
        tick();
        jogada  = 1'b0;
    endtask

    // Start a game and check INIT then first JOGANDO cycle.
    task automatic start_game(input logic n);
        iniciar = 1'b1;
        nivel   = n;
        tick();
        iniciar = 1'b0;
        vectors++;
        if ({estado, zera_pontos, reg_pontos, fim_jogo} !== {3'd1, 1'b1, 1'b0, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL start_init: got %b expected %b",
                     {estado, zera_pontos, reg_pontos, fim_jogo}, {3'd1, 1'b1, 1'b0, 1'b0});
        end
        tick();
        vectors++;
        if (obs() !== expv(3'd2, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0)) begin
            miscompares++;
            $display("[TB] FAIL start_jogando: got %h expected %h",
                     obs(), expv(3'd2, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_inputs();
        nivel = 1'b0;
        tick();
        tick();
        vectors++;
        if (obs() !== 15'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_state: got %h expected %h", obs(), 15'h0);
        end
        vectors++;
        if (obs4() !== 15'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_state_max4: got %h expected %h", obs4(), 15'h0);
        end
        reset = 1'b0;
        tick();
        vectors++;
        if (obs() !== 15'h0) begin
            miscompares++;
            $display("[TB] FAIL idle_hold: got %h expected %h", obs(), 15'h0);
        end
    endtask

    // Three errors and a correct move, then close the round.
    task automatic test_errors_and_close();
        start_game(1'b0);
        for (int i = 1; i <= 3; i++) begin
            error_pulse();
            vectors++;
            if (erros !== 4'(i)) begin
                miscompares++;
                $display("[TB] FAIL error_count: got %0d expected %0d", erros, i);
            end
        end
        jogada  = 1'b1;
        acertou = 1'b1;
        tick();
        jogada  = 1'b0;
        vectors++;
        if (obs() !== expv(3'd2, 4'd0, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0)) begin
            miscompares++;
            $display("[TB] FAIL correct_move: got %h expected %h",
                     obs(), expv(3'd2, 4'd0, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0));
        end
        fim_rodada = 1'b1;
        tick();
        fim_rodada = 1'b0;
        vectors++;
        if (obs() !== expv(3'd3, 4'd0, 4'd3, 1'b0, 1'b1, 1'b0, 1'b0)) begin
            miscompares++;
            $display("[TB] FAIL registra_r0: got %h expected %h",
                     obs(), expv(3'd3, 4'd0, 4'd3, 1'b0, 1'b1, 1'b0, 1'b0));
        end
        tick();
        vectors++;
        if (obs() !== expv(3'd2, 4'd1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0)) begin
            miscompares++;
            $display("[TB] FAIL next_round_r1: got %h expected %h",
                     obs(), expv(3'd2, 4'd1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        end
    endtask

    // Error and fim_rodada together, then inputs during REGISTRA are dropped.
    task automatic test_same_cycle();
        error_pulse();
        error_pulse();
        jogada     = 1'b1;
        acertou    = 1'b0;
        fim_rodada = 1'b1;
        tick();
        vectors++;
        if (obs() !== expv(3'd3, 4'd1, 4'd3, 1'b0, 1'b1, 1'b0, 1'b0)) begin
            miscompares++;
            $display("[TB] FAIL same_cycle_registra: got %h expected %h",
                     obs(), expv(3'd3, 4'd1, 4'd3, 1'b0, 1'b1, 1'b0, 1'b0));
        end
        iniciar = 1'b1;
        tick();
        clear_inputs();
        vectors++;
        if (obs() !== expv(3'd2, 4'd2, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0)) begin
            miscompares++;
            $display("[TB] FAIL registra_ignores_inputs: got %h expected %h",
                     obs(), expv(3'd2, 4'd2, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        end
        tick();
        vectors++;
        if (obs() !== expv(3'd2, 4'd2, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0)) begin
            miscompares++;
            $display("[TB] FAIL no_spurious_close: got %h expected %h",
                     obs(), expv(3'd2, 4'd2, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        end
    endtask

    // Full clean game; nivel and iniciar are wiggled mid-game and must be ignored.
    task automatic test_full_game(input logic n, input int rodadas);
        int strobes;
        logic last;
        strobes = 0;
        start_game(n);
        nivel = ~n;
        for (int r = 0; r < rodadas; r++) begin
            last = (r == rodadas - 1);
            if (r == 2) iniciar = 1'b1;
            fim_rodada = 1'b1;
            tick();
            fim_rodada = 1'b0;
            if (reg_pontos === 1'b1) strobes++;
            vectors++;
            if (obs() !== expv(3'd3, 4'(r), 4'd0, 1'b0, 1'b1, last, 1'b0)) begin
                miscompares++;
                $display("[TB] FAIL round_registra r=%0d: got %h expected %h",
                         r, obs(), expv(3'd3, 4'(r), 4'd0, 1'b0, 1'b1, last, 1'b0));
            end
            tick();
            iniciar = 1'b0;
            if (reg_pontos === 1'b1) strobes++;
            if (!last) begin
                vectors++;
                if (obs() !== expv(3'd2, 4'(r + 1), 4'd0, 1'b0, 1'b0, (r + 1 == rodadas - 1), 1'b0)) begin
                    miscompares++;
                    $display("[TB] FAIL round_advance r=%0d: got %h expected %h", r, obs(),
                             expv(3'd2, 4'(r + 1), 4'd0, 1'b0, 1'b0, (r + 1 == rodadas - 1), 1'b0));
                end
            end else begin
                vectors++;
                if (obs() !== expv(3'd4, 4'(r), 4'd0, 1'b0, 1'b0, 1'b1, 1'b1)) begin
                    miscompares++;
                    $display("[TB] FAIL game_over: got %h expected %h",
                             obs(), expv(3'd4, 4'(r), 4'd0, 1'b0, 1'b0, 1'b1, 1'b1));
                end
            end
        end
        vectors++;
        if (strobes !== rodadas) begin
            miscompares++;
            $display("[TB] FAIL strobe_count: got %0d expected %0d", strobes, rodadas);
        end
        tick();
        vectors++;
        if (obs() !== expv(3'd4, 4'(rodadas - 1), 4'd0, 1'b0, 1'b0, 1'b1, 1'b1)) begin
            miscompares++;
            $display("[TB] FAIL fim_hold: got %h expected %h",
                     obs(), expv(3'd4, 4'(rodadas - 1), 4'd0, 1'b0, 1'b0, 1'b1, 1'b1));
        end
    endtask

    // Limit 4 instance force-closes on the 4th error; limit 15 closes at 15.
    task automatic test_max_erros();
        do_reset();
        start_game(1'b0);
        for (int i = 1; i <= 3; i++) error_pulse();
        vectors++;
        if (obs4() !== expv(3'd2, 4'd0, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0)) begin
            miscompares++;
            $display("[TB] FAIL max4_below: got %h expected %h",
                     obs4(), expv(3'd2, 4'd0, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0));
        end
        error_pulse();
        vectors++;
        if (obs4() !== expv(3'd3, 4'd0, 4'd4, 1'b0, 1'b1, 1'b0, 1'b0)) begin
            miscompares++;
            $display("[TB] FAIL max4_forced: got %h expected %h",
                     obs4(), expv(3'd3, 4'd0, 4'd4, 1'b0, 1'b1, 1'b0, 1'b0));
        end
        vectors++;
        if (obs() !== expv(3'd2, 4'd0, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0)) begin
            miscompares++;
            $display("[TB] FAIL max15_still_open: got %h expected %h",
                     obs(), expv(3'd2, 4'd0, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0));
        end
        tick();
        vectors++;
        if (obs4() !== expv(3'd2, 4'd1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0)) begin
            miscompares++;
            $display("[TB] FAIL max4_next_round: got %h expected %h",
                     obs4(), expv(3'd2, 4'd1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        end
        for (int i = 5; i <= 14; i++) error_pulse();
        vectors++;
        if (obs() !== expv(3'd2, 4'd0, 4'd14, 1'b0, 1'b0, 1'b0, 1'b0)) begin
            miscompares++;
            $display("[TB] FAIL max15_at14: got %h expected %h",
                     obs(), expv(3'd2, 4'd0, 4'd14, 1'b0, 1'b0, 1'b0, 1'b0));
        end
        error_pulse();
        vectors++;
        if (obs() !== expv(3'd3, 4'd0, 4'd15, 1'b0, 1'b1, 1'b0, 1'b0)) begin
            miscompares++;
            $display("[TB] FAIL max15_forced: got %h expected %h",
                     obs(), expv(3'd3, 4'd0, 4'd15, 1'b0, 1'b1, 1'b0, 1'b0));
        end
    endtask

    // Reset mid-round at limite 5, erros 2, then restart from round 0.
    task automatic test_reset_mid_round();
        do_reset();
        start_game(1'b0);
        for (int r = 0; r < 5; r++) begin
            fim_rodada = 1'b1;
            tick();
            fim_rodada = 1'b0;
            tick();
        end
        error_pulse();
        error_pulse();
        vectors++;
        if (obs() !== expv(3'd2, 4'd5, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0)) begin
            miscompares++;
            $display("[TB] FAIL pre_reset: got %h expected %h",
                     obs(), expv(3'd2, 4'd5, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0));
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        vectors++;
        if (obs() !== 15'h0) begin
            miscompares++;
            $display("[TB] FAIL mid_round_reset: got %h expected %h", obs(), 15'h0);
        end
        start_game(1'b0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        nivel       = 1'b0;
        clear_inputs();
        test_reset();
        test_errors_and_close();
        test_same_cycle();
        do_reset();
        test_full_game(1'b0, 8);
        test_full_game(1'b1, 16);
        test_max_erros();
        test_reset_mid_round();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
